pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on misaligned redirect (see Configuration).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_ctr  input  1  redirect request from branch/jump decision logic; 1 = take target.
REQ-006 target  input  32  redirect address (branch/jump/jalr target from ALU).
REQ-007 stall  input  1  downstream hazard stall; 1 = do not accept a new instruction.
REQ-008 imem_req  output  1  instruction fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address.
REQ-010 imem_ready  input  1  instruction memory accepts/returns fetch this cycle.
REQ-011 inst_valid  output  1  fetch completed and accepted this cycle.
REQ-012 pc  output  32  address of current fetch.
REQ-013 pc_plus4  output  32  pc + 4, for link register writeback.
REQ-014 misalign  output  1  one-cycle pulse: redirect target not word-aligned.

Function
REQ-015 FSM states SHALL be BOOT, FETCH, HOLD.
REQ-016 BOOT SHALL last exactly one cycle after reset release, imem_req=0, then go to FETCH.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-018 Accept SHALL mean FETCH & imem_ready & ~stall; inst_valid SHALL equal accept, combinationally.
REQ-019 On accept, pc SHALL update at the next edge to the redirect address if pc_ctr or pending-redirect is set, else pc+4 (mod 2^32 wrap).
REQ-020 Redirect address SHALL be target with bit 0 cleared; pc_ctr in the same cycle SHALL take priority over a pending redirect.
REQ-021 If pc_ctr=1 in a cycle without accept, target SHALL be latched into a one-entry pending-redirect register; a later pc_ctr overwrites it.
REQ-022 Pending-redirect SHALL clear on the accept that consumes it.
REQ-023 FETCH & imem_ready & stall SHALL move to HOLD with imem_req=0 and pc unchanged.
REQ-024 HOLD SHALL return to FETCH on the first cycle stall=0; no fetch is issued while in HOLD.
REQ-025 pc_plus4 SHALL be combinational pc+4 at all times.

Reset
REQ-026 rst=1 SHALL set pc=RESET_VECTOR, state=BOOT, pending-redirect clear, imem_req=0, inst_valid=0, misalign=0.
REQ-027 rst asserted mid-fetch or in HOLD SHALL abandon the fetch and any pending redirect with no inst_valid issued.

Configuration
REQ-028 Macro PC_MISALIGN_TRAP_EN defined: a redirect address with bit 1 set SHALL pulse misalign for the accept cycle and load pc=TRAP_VECTOR instead.
REQ-029 Macro undefined: misalign SHALL be tied 0 and the redirect address SHALL be used unchecked (bit 0 still cleared).

Structure
REQ-030 Shared package pc_pkg SHALL hold the FSM state enum, XLEN=32 and INSN_BYTES=4 constants.
REQ-031 Sub-module pc_redirect_buf SHALL implement the one-entry pending-redirect register (valid + address, set/overwrite/clear).

Verification
REQ-032 Reset release, imem_ready=1, stall=0: pc sequence 0x0, 0x4, 0x8 on consecutive cycles after one BOOT cycle.
REQ-033 pc=0x10, pc_ctr=1, target=0x41, accept: next pc=0x40, pending stays clear.
REQ-034 pc=0x20, imem_ready=0, pc_ctr pulse target=0x80, ready=1 two cycles later: next pc=0x80, then 0x84.
REQ-035 stall=1 with imem_ready=1 at pc=0x8 for 3 cycles: imem_req=0, pc holds 0x8, no inst_valid; fetch resumes on release.
REQ-036 With PC_MISALIGN_TRAP_EN, target=0x102, accept: misalign=1 one cycle, pc=0x100; without macro pc=0x102, misalign=0.
REQ-037 pc=0xFFFF_FFFC accept with no redirect: pc wraps to 0x0; rst mid-HOLD: pc=RESET_VECTOR, state BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and FSM state type for the PC fetch unit.
package pc_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD
    } fetch_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect register: a valid bit plus the latched target.
module pc_redirect_buf
    import pc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [XLEN-1:0] set_addr,
    input  logic            clr,
    output logic            valid,
    output logic [XLEN-1:0] addr
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] addr_q,  addr_d;

    // A new redirect overwrites any older one; clear only drops the valid bit.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (set_en) begin
            valid_d = 1'b1;
            addr_d  = set_addr;
        end else if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid = valid_q;
    assign addr  = addr_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC sequencing and instruction-fetch handshake (BOOT/FETCH/HOLD).
// Define PC_MISALIGN_TRAP_EN to trap redirects whose target has bit 1 set.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_ctr,
    input  logic [XLEN-1:0] target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            accept;
    logic            pend_valid;
    logic [XLEN-1:0] pend_addr;
    logic            redirect_take;
    logic [XLEN-1:0] redirect_addr;
    logic            trap_hit;

    pc_redirect_buf u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .set_en   (pc_ctr & ~accept),
        .set_addr (target),
        .clr      (accept),
        .valid    (pend_valid),
        .addr     (pend_addr)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req      = 1'b0;
        accept        = 1'b0;
        misalign      = 1'b0;
        redirect_take = pc_ctr | pend_valid;
        redirect_addr = (pc_ctr ? target : pend_addr) & ~XLEN'(1);
`ifdef PC_MISALIGN_TRAP_EN
        trap_hit      = redirect_take & redirect_addr[1];
`else
        trap_hit      = 1'b0;
`endif

        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (stall) state_d = ST_HOLD;
                    else       accept  = 1'b1;
                end
            end
            ST_HOLD:  if (!stall) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase

        // Reset is synchronous, so a FETCH state seen during rst must not leak outputs.
        if (rst) begin
            imem_req = 1'b0;
            accept   = 1'b0;
        end

        if (accept) begin
            misalign = trap_hit;
            if (redirect_take) pc_d = trap_hit ? TRAP_VECTOR : redirect_addr;
            else               pc_d = pc_q + XLEN'(INSN_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign inst_valid = accept;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + XLEN'(INSN_BYTES);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then random traffic
// against a cycle-level behavioural model. Honours PC_MISALIGN_TRAP_EN.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, pc_ctr, stall, imem_ready;
    logic [31:0] target;
    logic        imem_req, inst_valid, misalign;
    logic [31:0] imem_addr, pc, pc_plus4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: phase 0 = boot cycle, 1 = fetching, 2 = held off by stall.
    int          m_phase = 0;
    bit          m_known = 1'b0;
    logic [31:0] m_pc    = '0;
    bit          m_pv    = 1'b0;
    logic [31:0] m_pa    = '0;

    pc_fetch_unit #(
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_ctr     (pc_ctr),
        .target     (target),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance model, cross the edge.
    task automatic step(input logic r, input logic c, input logic [31:0] t,
                        input logic s, input logic y);
        bit          e_req, e_acc, e_redir, e_mis;
        logic [31:0] e_addr;
        rst = r; pc_ctr = c; target = t; stall = s; imem_ready = y;
        #2;
        e_req   = !r && m_phase == 1;
        e_acc   = e_req && y && !s;
        e_redir = c || m_pv;
        e_addr  = c ? t : m_pa;
        e_addr[0] = 1'b0;
        e_mis   = TRAP_EN && e_acc && e_redir && e_addr[1];
        check_eq("imem_req", 32'(imem_req), 32'(e_req));
        check_eq("inst_valid", 32'(inst_valid), 32'(e_acc));
        check_eq("misalign", 32'(misalign), 32'(e_mis));
        if (m_known) begin
            check_eq("pc", pc, m_pc);
            check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
            if (e_req) check_eq("imem_addr", imem_addr, m_pc);
        end
        if (r) begin
            m_pc = RV; m_phase = 0; m_pv = 1'b0; m_known = 1'b1;
        end else begin
            if (e_acc) begin
                if (!e_redir)  m_pc = m_pc + 32'd4;
                else if (e_mis) m_pc = TV;
                else           m_pc = e_addr;
                m_pv = 1'b0;
            end else if (c) begin
                m_pv = 1'b1; m_pa = t;
            end
            case (m_phase)
                0:       m_phase = 1;
                1:       if (y && s) m_phase = 2;
                default: if (!s) m_phase = 1;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_ctr = 1'b0; target = '0; stall = 1'b0; imem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check_eq("reset_pc", pc, RV);

        // Boot cycle then sequential fetch 0,4,8
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_eq("seq_pc8", pc, 32'h8);

        // Stall three cycles at 0x8, then release
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        check_eq("stall_pc_hold", pc, 32'h8);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_eq("resume_pc10", pc, 32'h10);

        // Immediate redirect, bit 0 cleared
        step(0, 1, 32'h41, 0, 1);
        check_eq("redir_pc40", pc, 32'h40);

        // Pending redirect held across not-ready cycles
        step(0, 1, 32'h20, 0, 1);
        step(0, 1, 32'h80, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check_eq("pend_pc80", pc, 32'h80);
        step(0, 0, 0, 0, 1);
        check_eq("pend_pc84", pc, 32'h84);

        // Misaligned redirect target
        step(0, 1, 32'h102, 0, 1);
        check_eq("misalign_pc", pc, TRAP_EN ? TV : 32'h102);

        // Wrap at top of address space
        step(0, 1, 32'hFFFF_FFFC, 0, 1);
        step(0, 0, 0, 0, 1);
        check_eq("wrap_pc0", pc, 32'h0);

        // Reset while held with a pending redirect
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h44, 1, 0);
        step(1, 0, 0, 1, 0);
        check_eq("hold_rst_pc", pc, RV);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_eq("rst_drops_pend", pc, RV + 32'd4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t = t & 32'h0000_0FFF;
            step(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 t,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
